// File: rtl/reg_readback_pkg.sv
// Shared types and helpers for the register read-back responder.
// Optional assertions in reg_readback are enabled with REG_READBACK_SVA_EN.
package reg_readback_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rr_state_t;

  // One address bit beyond the bank index so out-of-range reads are visible.
  function automatic int unsigned rr_aw(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_readback_mux.sv
// Combinational word select from the packed register bank, with out-of-range flag.
module reg_readback_mux
  import reg_readback_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4,
  parameter int unsigned aw    = rr_aw(depth)
) (
  input  logic [depth*width-1:0] i_regs,
  input  logic [aw-1:0]          i_addr,
  output logic [width-1:0]       o_word_c,
  output logic                   o_oor_c
);

  // Full-width compare: no truncation, so aliased high addresses never hit a word.
  assign o_oor_c = (i_addr >= aw'(depth));

  always_comb begin
    o_word_c = '0;
    for (int unsigned k = 0; k < depth; k++) begin
      if (i_addr == aw'(k)) begin
        o_word_c = i_regs[k*width +: width];
      end
    end
  end

endmodule

// File: rtl/reg_readback.sv
// Read-side responder: accepts an address, snapshots the register word, holds it until consumed.
// Define REG_READBACK_SVA_EN to compile in the protocol assertions.
module reg_readback
  import reg_readback_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4,
  parameter int unsigned aw    = rr_aw(depth)
) (
  input  logic                   clk,
  input  logic                   resetna,
  input  logic                   resetns,
  input  logic [depth*width-1:0] regs_i,
  input  logic [aw-1:0]          req_addr,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [width-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   rsp_valid,
  input  logic                   rsp_ready
);

  rr_state_t        r_state;
  logic [width-1:0] r_data;
  logic             r_err;
  logic             r_valid;

  logic [width-1:0] w_word;
  logic             w_oor;
  logic             w_accept;

  reg_readback_mux #(
    .width (width),
    .depth (depth),
    .aw    (aw)
  ) u_mux (
    .i_regs   (regs_i),
    .i_addr   (req_addr),
    .o_word_c (w_word),
    .o_oor_c  (w_oor)
  );

  // A held response frees the slot in the same cycle it is consumed.
  assign req_ready = (r_state == IDLE) || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge resetna) begin
    if (!resetna) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (!resetns) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state <= RESP;
        r_valid <= 1'b1;
        r_err   <= w_oor;
        r_data  <= w_oor ? '0 : w_word;
      end else if ((r_state == RESP) && rsp_ready) begin
        // Data and error keep their last value after the response drains.
        r_state <= IDLE;
        r_valid <= 1'b0;
      end
    end
  end

  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign rsp_valid = r_valid;

`ifdef REG_READBACK_SVA_EN
  a_hold_stable: assert property (@(posedge clk) disable iff (!resetna)
    (resetns && rsp_valid && !rsp_ready) |=> ($stable(rsp_data) && $stable(rsp_err)))
    else $error("reg_readback: rsp_data/rsp_err changed while response stalled");

  a_rsp_latency: assert property (@(posedge clk) disable iff (!resetna)
    (resetns && req_valid && req_ready) |=> rsp_valid)
    else $error("reg_readback: rsp_valid not asserted one cycle after request handshake");

  a_rsp_cause: assert property (@(posedge clk) disable iff (!resetna)
    $rose(rsp_valid) |-> $past(req_valid && req_ready))
    else $error("reg_readback: rsp_valid rose without a preceding request handshake");

  a_err_zero: assert property (@(posedge clk) disable iff (!resetna)
    rsp_err |-> (rsp_data == '0))
    else $error("reg_readback: rsp_err set with non-zero rsp_data");

  a_no_x: assert property (@(posedge clk) disable iff (!resetna)
    !$isunknown({req_valid, rsp_valid, req_ready}))
    else $error("reg_readback: X on req_valid/rsp_valid/req_ready out of reset");
`endif

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: directed table, stall/reset sequences, random vs. model.
module tb_reg_readback;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          resetna, resetns;
  logic [AW-1:0] req_addr;
  logic          req_valid, req_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_err, rsp_valid, rsp_ready;
  logic [7:0]    words [4];
  logic [D*W-1:0] regs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign regs = {words[3], words[2], words[1], words[0]};

  reg_readback #(.width(W), .depth(D), .aw(AW)) dut (
    .clk       (clk),
    .resetna   (resetna),
    .resetns   (resetns),
    .regs_i    (regs),
    .req_addr  (req_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          valid;
    logic          rready;
    logic          exp_rr;
    logic          exp_v;
    logic [7:0]    exp_d;
    logic          exp_e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic v, input logic r);
    req_addr  = a;
    req_valid = v;
    rsp_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int a, input bit v, input bit r, input bit rr,
                              input bit ev, input int ed, input bit ee);
    vec_t t;
    t.addr = AW'(a); t.valid = v; t.rready = r; t.exp_rr = rr;
    t.exp_v = ev; t.exp_d = 8'(ed); t.exp_e = ee;
    return t;
  endfunction

  // Reference model state: the response the host should currently see.
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_err;

  initial begin
    resetna = 1'b0; resetns = 1'b1;
    req_addr = '0; req_valid = 1'b0; rsp_ready = 1'b0;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

    // Reset state, during and after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data",  32'(rsp_data),  0);
    chk("rst_err",   32'(rsp_err),   0);
    chk("rst_rready", 32'(req_ready), 1);
    resetna = 1'b1;
    tick();
    chk("post_rst_valid",  32'(rsp_valid), 0);
    chk("post_rst_data",   32'(rsp_data),  0);
    chk("post_rst_err",    32'(rsp_err),   0);
    chk("post_rst_rready", 32'(req_ready), 1);

    // Basic read, out-of-range, back-to-back, boundary addresses
    tbl.push_back(mk(2, 1, 1, 1, 1, 'h33, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h33, 0));
    tbl.push_back(mk(5, 1, 1, 1, 1, 'h00, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 'h11, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 'h22, 0));
    tbl.push_back(mk(2, 1, 1, 1, 1, 'h33, 0));
    tbl.push_back(mk(3, 1, 1, 1, 1, 'h44, 0));
    tbl.push_back(mk(4, 1, 1, 1, 1, 'h00, 1));
    tbl.push_back(mk(7, 1, 1, 1, 1, 'h00, 1));
    tbl.push_back(mk(3, 1, 1, 1, 1, 'h44, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h44, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 'h44, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].addr, tbl[i].valid, tbl[i].rready);
      chk($sformatf("tbl%0d_rready", i), 32'(req_ready), 32'(tbl[i].exp_rr));
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_data", i),  32'(rsp_data),  32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_err", i),   32'(rsp_err),   32'(tbl[i].exp_e));
    end

    // Backpressure with snapshot: word1 changes mid-stall, competing request ignored
    drive(1, 1, 0);
    chk("stall_accept_rready", 32'(req_ready), 1);
    tick();
    chk("stall_first_valid", 32'(rsp_valid), 1);
    chk("stall_first_data",  32'(rsp_data),  'h22);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) words[1] = 8'hAA;
      drive(3, 1, 0);
      chk($sformatf("stall%0d_rready", i), 32'(req_ready), 0);
      tick();
      chk($sformatf("stall%0d_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("stall%0d_data", i),  32'(rsp_data),  'h22);
    end
    drive(0, 0, 1);
    chk("stall_release_rready", 32'(req_ready), 1);
    tick();
    chk("stall_done_valid", 32'(rsp_valid), 0);
    chk("stall_done_data",  32'(rsp_data),  'h22);
    words[1] = 8'h22;

    // Sync reset discards a held response
    drive(2, 1, 0);
    tick();
    chk("srst_held_valid", 32'(rsp_valid), 1);
    chk("srst_held_data",  32'(rsp_data),  'h33);
    resetns = 1'b0;
    drive(0, 0, 0);
    tick();
    resetns = 1'b1;
    chk("srst_valid", 32'(rsp_valid), 0);
    chk("srst_data",  32'(rsp_data),  0);
    chk("srst_err",   32'(rsp_err),   0);
    drive(0, 0, 1);
    tick();
    chk("srst_no_replay", 32'(rsp_valid), 0);
    // Sync reset wins over a simultaneous handshake
    resetns = 1'b0;
    drive(1, 1, 1);
    tick();
    resetns = 1'b1;
    chk("srst_prio_valid", 32'(rsp_valid), 0);
    chk("srst_prio_data",  32'(rsp_data),  0);

    // Random traffic against the reference model
    m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] a;
      logic v, r, rr_exp;
      int unsigned ai;
      if ($urandom_range(0, 3) == 0) words[$urandom_range(0, 3)] = 8'($urandom);
      resetns = ($urandom_range(0, 39) != 0);
      a = AW'($urandom_range(0, 7));
      v = 1'($urandom);
      r = 1'($urandom);
      drive(a, v, r);
      rr_exp = !m_valid || r;
      chk($sformatf("rnd%0d_rready", c), 32'(req_ready), 32'(rr_exp));
      ai = a;
      if (!resetns) begin
        m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0;
      end else if (v && rr_exp) begin
        m_valid = 1'b1;
        m_err   = (ai >= D);
        m_data  = m_err ? 8'h00 : words[ai];
      end else if (r) begin
        m_valid = 1'b0;
      end
      tick();
      chk($sformatf("rnd%0d_valid", c), 32'(rsp_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_data", c),  32'(rsp_data),  32'(m_data));
      chk($sformatf("rnd%0d_err", c),   32'(rsp_err),   32'(m_err));
    end
    resetns = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
